digit_reverse9: RTL and testbench
=================================

# digit_reverse9

Output reorder stage placed directly downstream of the 9-point radix-3 SDF FFT (`SdfUnit9`). The FFT emits each 9-sample frame in radix-3 digit-reversed order; this block buffers each frame and re-emits it in natural frequency order (k = 0..8). A ping-pong (double-bank) buffer lets back-to-back frames stream without stalls.

## Interface
- WIDTH, 16, bit width of each real/imag component
- clk  in  1  master clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous abort: discards the partial input frame and any in-progress readout
- di_en  in  1  input sample valid (the FFT's do_en)
- di_re  in  WIDTH  input real
- di_im  in  WIDTH  input imag
- do_en  out  1  output sample valid
- do_re  out  WIDTH  output real, natural order
- do_im  out  WIDTH  output imag, natural order
- do_idx  out  4  frequency index k of the current output, 0..8
- do_last  out  1  high with k = 8

## Operation
- Frame: 9 samples accepted on clk edges where di_en = 1.
  - di_en gaps inside a frame are allowed; the write counter holds during a gap.
- Write side: wr_cnt 0..8 addresses bank wr_bank.
  - On the edge that writes wr_cnt = 8: wr_cnt wraps to 0, wr_bank toggles, and a readout of the just-filled bank is launched.
- Read side: rd_cnt 0..8 runs on 9 consecutive cycles, never stalled.
  - Read address = DIGREV9[rd_cnt], which maps k = 3*k1 + k0 to stored address 3*k0 + k1.
  - Read sequence: 0, 3, 6, 1, 4, 7, 2, 5, 8.
- Back-to-back frames: a write takes at least 9 cycles and a readout takes exactly 9, so the next launch never collides with an active readout.
  - If a launch nevertheless coincides with an active readout, the new readout takes precedence: rd_cnt restarts at 0 on the new bank.
- flush: clears wr_cnt, rd_cnt and the read-active flag next edge; do_en = 0 from the following cycle.
  - wr_bank is unchanged. Takes priority over a simultaneous di_en.
- Arithmetic: none. Data passes bit-exact, no scaling.

## Timing
- Reset (async, immediate): wr_cnt = 0, rd_cnt = 0, wr_bank = 0, read inactive, do_en = 0, do_re = 0, do_im = 0, do_idx = 0, do_last = 0.
  - Buffer contents are not reset.
- Let edge E8 be the edge that writes the 9th sample of a frame.
  - The RAM read for k = 0 occurs at E8+1 (registered output).
  - do_en is high in the cycle after E8+1 through the cycle after E8+9, i.e. 9 cycles.
- Latency: first output valid 2 cycles after the last input sample is presented; 10 cycles after the first sample when the input is contiguous.
- do_re, do_im, do_idx and do_last are registered. When do_en = 0 they hold their last values, except do_last = 0.
- Reset during readout aborts it; the next frame starts writing at wr_cnt = 0 into bank 0.
- Throughput: one sample per clock, sustained.

## Structure
- Shared package fft9_pkg:
  - FRAME_LEN = 9
  - DIGREV9: 9-entry constant lookup table {0, 3, 6, 1, 4, 7, 2, 5, 8}
  - the bank-count constant, 2
- Sub-module reorder_ram: simple dual-port RAM.
  - 18 entries × 2*WIDTH bits.
  - One synchronous write port, one synchronous-read port, no reset.
  - Address = {bank, 4-bit index}.
- Top level holds the counters, bank select, launch/flush logic and output registers.

## Test plan
- Reset then one frame: di_re = 0..8, di_im = 100..108, contiguous.
  - do_re = 0, 3, 6, 1, 4, 7, 2, 5, 8 on 9 consecutive cycles, with di_im permuted the same way.
  - do_idx = 0..8, do_last only on the 9th output, first do_en 2 cycles after the last input.
- Three back-to-back frames (27 contiguous inputs, values 0..26).
  - 27 contiguous outputs; frame f outputs = 9f + DIGREV9[k]; no gap, no corruption.
- Input frame with di_en low for 3 cycles after sample 4.
  - Output order unchanged.
  - Readout begins 2 cycles after the delayed last sample.
- Full-scale values 0x7FFF / 0x8000 alternating.
  - Bit-exact passthrough in permuted order.
- flush asserted after 5 samples, then a full frame 50..58.
  - No output for the partial frame; the next output is 50, 53, 56, 51, 54, 57, 52, 55, 58.
- rst asserted asynchronously at output k = 4.
  - All outputs go to 0 immediately.
  - A subsequent frame outputs correctly from bank 0.

Source files
------------

// File: rtl/fft9_pkg.sv
// fft9_pkg: constants and types shared by the 9-point FFT output stages.
//   FRAME_LEN : samples per FFT frame
//   NUM_BANKS : ping-pong bank count of the reorder buffer
//   DIGREV9   : natural index k = 3*k1 + k0 -> stored address 3*k0 + k1
//   ram_addr_t: reorder RAM address, {bank, 4-bit index}
package fft9_pkg;

    localparam int FRAME_LEN = 9;
    localparam int NUM_BANKS = 2;
    localparam int IDX_W     = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    // Element [0] is the rightmost entry: read sequence 0,3,6,1,4,7,2,5,8.
    localparam logic [FRAME_LEN-1:0][IDX_W-1:0] DIGREV9 =
        {4'd8, 4'd5, 4'd2, 4'd7, 4'd4, 4'd1, 4'd6, 4'd3, 4'd0};

    typedef struct packed {
        logic             bank;
        logic [IDX_W-1:0] idx;
    } ram_addr_t;

endpackage

// File: rtl/digit_reverse9_if.sv
// digit_reverse9_if: sample stream into and out of the digit-reverse stage.
//   flush                : synchronous abort of partial frame / readout
//   di_en, di_re, di_im  : digit-reversed input samples (FFT side)
//   do_en, do_re, do_im  : natural-order output samples
//   do_idx, do_last      : frequency index k of the output, k == 8 marker
//   master modport drives the inputs, slave modport is the reorder stage.
interface digit_reverse9_if #(
    parameter int WIDTH = 16
);
    logic                    flush;
    logic                    di_en;
    logic signed [WIDTH-1:0] di_re;
    logic signed [WIDTH-1:0] di_im;
    logic                    do_en;
    logic signed [WIDTH-1:0] do_re;
    logic signed [WIDTH-1:0] do_im;
    logic [3:0]              do_idx;
    logic                    do_last;

    modport master (
        output flush, di_en, di_re, di_im,
        input  do_en, do_re, do_im, do_idx, do_last
    );

    modport slave (
        input  flush, di_en, di_re, di_im,
        output do_en, do_re, do_im, do_idx, do_last
    );
endinterface

// File: rtl/reorder_ram.sv
// reorder_ram: simple dual-port frame buffer, two banks of FRAME_LEN words.
//   clk              : clock
//   we_i/waddr_i/wdata_i : synchronous write port
//   re_i/raddr_i     : synchronous read port; rdata_o holds when re_i = 0
//   rdata_o          : registered read data {re, im}
// No reset: contents and read register power up undefined.
module reorder_ram
    import fft9_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               we_i,
    input  ram_addr_t          waddr_i,
    input  logic [2*WIDTH-1:0] wdata_i,
    input  logic               re_i,
    input  ram_addr_t          raddr_i,
    output logic [2*WIDTH-1:0] rdata_o
);

    logic [2*WIDTH-1:0] mem_q [NUM_BANKS][FRAME_LEN];
    logic [2*WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i.bank][waddr_i.idx] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i.bank][raddr_i.idx];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/digit_reverse9.sv
// digit_reverse9: reorders 9-sample radix-3 digit-reversed FFT frames into
// natural frequency order using a ping-pong buffer.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : digit_reverse9_if slave (flush, di_*, do_*)
// Output appears 2 cycles after the last sample of a frame and streams for
// 9 consecutive cycles; back-to-back frames stream without gaps.
module digit_reverse9
    import fft9_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    digit_reverse9_if.slave  bus
);

    logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_active_q, rd_active_d;
    logic             do_en_q, do_en_d;
    logic [IDX_W-1:0] do_idx_q, do_idx_d;
    logic             do_last_q, do_last_d;
    logic             data_vld_q, data_vld_d;

    logic             wr_fire;
    logic             launch;
    logic             rd_fire;
    ram_addr_t        waddr;
    ram_addr_t        raddr;
    logic [2*WIDTH-1:0] rdata;

    always_comb begin
        wr_fire = bus.di_en && !bus.flush;
        launch  = wr_fire && (wr_cnt_q == LAST_IDX);
        // A flushed cycle performs no RAM read so the output data holds.
        rd_fire = rd_active_q && !bus.flush;

        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_cnt_d    = rd_cnt_q;
        rd_active_d = rd_active_q;

        if (bus.flush) begin
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            rd_active_d = 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt_d = launch ? '0 : wr_cnt_q + 1'b1;
            end
            if (launch) begin
                wr_bank_d = ~wr_bank_q;
            end
            if (rd_active_q) begin
                if (rd_cnt_q == LAST_IDX) begin
                    rd_cnt_d    = '0;
                    rd_active_d = 1'b0;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            // A new launch wins over a readout still in progress.
            if (launch) begin
                rd_cnt_d    = '0;
                rd_active_d = 1'b1;
            end
        end

        do_en_d    = rd_fire;
        do_idx_d   = rd_fire ? rd_cnt_q : do_idx_q;
        do_last_d  = rd_fire && (rd_cnt_q == LAST_IDX);
        data_vld_d = data_vld_q || rd_fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            rd_active_q <= 1'b0;
            do_en_q     <= 1'b0;
            do_idx_q    <= '0;
            do_last_q   <= 1'b0;
            data_vld_q  <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_active_q <= rd_active_d;
            do_en_q     <= do_en_d;
            do_idx_q    <= do_idx_d;
            do_last_q   <= do_last_d;
            data_vld_q  <= data_vld_d;
        end
    end

    // The bank being read is always the one the writer just left: every
    // launch toggles wr_bank, and flush cancels any readout.
    assign waddr = '{bank: wr_bank_q, idx: wr_cnt_q};
    assign raddr = '{bank: ~wr_bank_q, idx: DIGREV9[rd_cnt_q]};

    reorder_ram #(.WIDTH(WIDTH)) u_ram (
        .clk     (clk),
        .we_i    (wr_fire),
        .waddr_i (waddr),
        .wdata_i ({bus.di_re, bus.di_im}),
        .re_i    (rd_fire),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // The RAM read register has no reset; mask it to zero until the first
    // read after reset so the data outputs come out of reset cleared.
    assign bus.do_en   = do_en_q;
    assign bus.do_idx  = do_idx_q;
    assign bus.do_last = do_last_q;
    assign bus.do_re   = data_vld_q ? rdata[2*WIDTH-1:WIDTH] : '0;
    assign bus.do_im   = data_vld_q ? rdata[WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_digit_reverse9.sv
// tb_digit_reverse9: self-checking bench for digit_reverse9.
// A frame-level reference model collects accepted samples and, on the 9th,
// schedules the natural-order outputs k = 0..8 (source index 3*(k%3)+k/3)
// for the cycles after the next edge; every cycle the outputs are compared
// against that schedule, or against the held values when idle.
module tb_digit_reverse9;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    digit_reverse9_if #(.WIDTH(W)) bus();

    digit_reverse9 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        logic [3:0]          idx;
    } exp_t;

    exp_t                exp_q[int];
    logic signed [W-1:0] frm_re[$];
    logic signed [W-1:0] frm_im[$];
    logic signed [W-1:0] last_re  = '0;
    logic signed [W-1:0] last_im  = '0;
    logic [3:0]          last_idx = '0;

    typedef struct {
        logic signed [W-1:0] in_re;
        logic signed [W-1:0] in_im;
        logic signed [W-1:0] out_re;
        logic signed [W-1:0] out_im;
        logic [3:0]          out_idx;
        logic                out_last;
    } vec_t;

    vec_t tbl[9];
    int   perm[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};

    function automatic logic [63:0] mk(input logic en, input logic [W-1:0] re,
                                       input logic [W-1:0] im, input logic [3:0] idx,
                                       input logic last);
        return 64'({en, re, im, idx, last});
    endfunction

    function automatic logic [63:0] snap();
        return 64'({bus.do_en, bus.do_re, bus.do_im, bus.do_idx, bus.do_last});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: frame assembly at the sampling edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            frm_re.delete();
            frm_im.delete();
            exp_q.delete();
        end else if (bus.flush) begin
            frm_re.delete();
            frm_im.delete();
            for (int j = cyc; j < cyc + 12; j++)
                if (exp_q.exists(j)) exp_q.delete(j);
        end else if (bus.di_en) begin
            frm_re.push_back(bus.di_re);
            frm_im.push_back(bus.di_im);
            if (frm_re.size() == 9) begin
                for (int k = 0; k < 9; k++) begin
                    int src;
                    src = 3 * (k % 3) + k / 3;
                    exp_q[cyc + 1 + k] = '{re: frm_re[src], im: frm_im[src], idx: 4'(k)};
                end
                frm_re.delete();
                frm_im.delete();
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst) begin
                chk("reset_outputs", snap(), 64'd0);
                last_re  = '0;
                last_im  = '0;
                last_idx = '0;
            end else if (exp_q.exists(cyc)) begin
                chk("model_out", snap(),
                    mk(1'b1, exp_q[cyc].re, exp_q[cyc].im, exp_q[cyc].idx, exp_q[cyc].idx == 4'd8));
                last_re  = exp_q[cyc].re;
                last_im  = exp_q[cyc].im;
                last_idx = exp_q[cyc].idx;
                exp_q.delete(cyc);
            end else begin
                chk("model_idle", snap(), mk(1'b0, last_re, last_im, last_idx, 1'b0));
            end
        end
    end

    task automatic send(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
        bus.di_en = 1'b1;
        bus.di_re = re;
        bus.di_im = im;
        @(posedge clk);
        #1;
        bus.di_en = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.di_en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end by 100000");
        $fatal(1);
    end

    initial begin
        int  found;
        int  r;
        bus.flush = 1'b0;
        bus.di_en = 1'b0;
        bus.di_re = '0;
        bus.di_im = '0;

        for (int i = 0; i < 9; i++) begin
            tbl[i].in_re    = W'(i);
            tbl[i].in_im    = W'(100 + i);
            tbl[i].out_re   = W'(perm[i]);
            tbl[i].out_im   = W'(100 + perm[i]);
            tbl[i].out_idx  = 4'(i);
            tbl[i].out_last = (i == 8);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", snap(), 64'd0);
        rst = 1'b0;
        idle(2);

        // One contiguous frame, checked against the table.
        for (int i = 0; i < 9; i++) send(tbl[i].in_re, tbl[i].in_im);
        @(negedge clk);
        chk("t1_no_early_output", 64'(bus.do_en), 64'd0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("t1_table_out", snap(),
                mk(1'b1, tbl[k].out_re, tbl[k].out_im, tbl[k].out_idx, tbl[k].out_last));
        end
        @(negedge clk);
        chk("t1_after_frame", 64'({bus.do_en, bus.do_last}), 64'd0);
        @(posedge clk);
        #1;
        idle(2);

        // Three back-to-back frames.
        for (int i = 0; i < 27; i++) send(W'(i), W'(-i));
        idle(12);

        // Gap of 3 cycles after sample 4.
        for (int i = 0; i < 4; i++) send(W'(20 + i), W'(40 + i));
        idle(3);
        for (int i = 4; i < 9; i++) send(W'(20 + i), W'(40 + i));
        idle(12);

        // Full-scale alternating values.
        for (int i = 0; i < 9; i++)
            send((i % 2) ? 16'sh8000 : 16'sh7FFF, (i % 2) ? 16'sh7FFF : 16'sh8000);
        idle(12);

        // Flush after 5 samples (with di_en also high), then a full frame.
        for (int i = 0; i < 5; i++) send(W'(30 + i), W'(130 + i));
        bus.flush = 1'b1;
        bus.di_en = 1'b1;
        bus.di_re = W'(99);
        bus.di_im = W'(199);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.di_en = 1'b0;
        for (int i = 0; i < 9; i++) send(W'(50 + i), W'(150 + i));
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("flush_next_frame", 64'({bus.do_en, bus.do_re}), 64'({1'b1, W'(50 + perm[k])}));
        end
        @(posedge clk);
        #1;
        idle(3);

        // Asynchronous reset while output k = 4 is on the bus.
        for (int i = 0; i < 9; i++) send(W'(70 + i), W'(170 + i));
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            @(negedge clk);
            if (bus.do_en && bus.do_idx == 4'd4) found = 1;
        end
        chk("rst_wait_k4", 64'(found), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_immediate", snap(), 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) send(W'(200 + i), W'(300 + i));
        idle(12);

        // Randomized traffic with gaps and occasional flushes.
        for (int n = 0; n < 500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                bus.flush = 1'b1;
                bus.di_en = 1'($urandom_range(0, 1));
                bus.di_re = 16'($urandom);
                bus.di_im = 16'($urandom);
                @(posedge clk);
                #1;
                bus.flush = 1'b0;
                bus.di_en = 1'b0;
            end else if (r < 80) begin
                send(16'($urandom), 16'($urandom));
            end else begin
                idle(1);
            end
        end
        idle(15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
